if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 stall  in  6  ctrl stall vector; bit0 = hold PC/IF.
REQ-004 branch_flag  in  1  redirect request from EX.
REQ-005 branch_target  in  32  redirect PC.
REQ-006 mem_grant  in  1  arbiter accepts if_mem_addr this cycle.
REQ-007 mem_byte  in  8  read byte, valid the cycle after an accepted address.
REQ-008 if_mem_req  out  1  IF requests memory port.
REQ-009 if_mem_addr  out  32  byte address requested.
REQ-010 if_pc  out  32  PC of presented instruction, to if_id.
REQ-011 if_inst  out  32  fetched instruction, little-endian assembled, to if_id.
REQ-012 stallreq_if  out  1  fetch incomplete; ctrl must stall stages 0..1.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, DONE.
REQ-014 IDLE -> FETCH unconditionally on the next edge; issue index and receive index both cleared.
REQ-015 In FETCH, if_mem_req SHALL be high while issue index < 4; if_mem_addr = pc + issue index.
REQ-016 Issue index SHALL increment only in cycles with if_mem_req and mem_grant both high.
REQ-017 A byte issued in cycle N SHALL be captured from mem_byte in cycle N+1 into inst bits [8k+7:8k], k = receive index; receive index then increments.
REQ-018 mem_grant low SHALL pause issuing without losing captured bytes or an in-flight byte.
REQ-019 On the 4th byte capture, FSM SHALL enter DONE; if_inst/if_pc SHALL update to assembled word/pc the same edge.
REQ-020 stallreq_if SHALL be high in IDLE and FETCH, low in DONE.
REQ-021 In DONE with stall[0]=0: pc <= pc+4 (mod 2^32), next state FETCH.
REQ-022 In DONE with stall[0]=1: pc, if_pc, if_inst, state held.
REQ-023 branch_flag=1 in any state SHALL on the next edge: pc <= branch_target, state FETCH, indices cleared, any in-flight byte discarded, if_inst <= 0, if_pc <= 0.
REQ-024 branch_flag SHALL take priority over stall[0] and over a simultaneous 4th-byte capture.
REQ-025 Best-case latency per instruction: 5 cycles from FETCH entry to DONE (4 issues + 1 capture).
REQ-026 Address arithmetic SHALL wrap modulo 2^32; no alignment check.

Reset
REQ-027 rst low SHALL asynchronously force: state IDLE, pc 0, indices 0, if_pc 0, if_inst 0, if_mem_req 0, if_mem_addr 0.
REQ-028 stallreq_if SHALL be 1 during and immediately after reset.
REQ-029 Reset asserted mid-fetch SHALL drop partial bytes; first fetch after release starts at address 0.

Configuration
REQ-030 Macro IF_ICACHE_EN SHALL compile in a 16-entry direct-mapped instruction cache: index pc[5:2], tag pc[17:6], one valid bit per entry.
REQ-031 With IF_ICACHE_EN: on FETCH entry, a hit SHALL go to DONE the next edge with zero memory requests; a miss fetches per REQ-015..019 and fills the entry on completion.
REQ-032 With IF_ICACHE_EN: reset SHALL clear all valid bits; branch-aborted fetches SHALL NOT fill.
REQ-033 Without IF_ICACHE_EN: no cache storage; every fetch goes to memory.

Verification
REQ-034 Reset release, mem_grant tied 1, memory bytes 13,00,00,00 at 0..3 -> if_inst=0x00000013, if_pc=0 five cycles after FETCH entry, stallreq_if low that cycle.
REQ-035 mem_grant low for 3 cycles after 2nd issue -> captured bytes preserved, DONE 3 cycles later than REQ-034, correct word.
REQ-036 stall[0]=1 held 4 cycles in DONE -> if_pc/if_inst stable, no if_mem_req; release -> fetch at pc+4.
REQ-037 branch_flag with target 0x100 asserted coincident with 4th byte capture -> stale word not presented; next fetch addresses 0x100..0x103.
REQ-038 rst low mid-fetch (2 bytes received) -> all outputs zero immediately; restart at address 0.
REQ-039 IF_ICACHE_EN: loop 0x0..0x8 fetched twice -> second pass hits, zero if_mem_req, DONE one cycle after FETCH entry.

Source files
------------

// File: rtl/if_fetch_if.sv
// Byte-wide instruction memory port between the fetch stage (master) and the
// memory arbiter (slave).
interface if_fetch_if;
    logic        if_mem_req;
    logic [31:0] if_mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_byte;

    modport master (
        output if_mem_req,
        output if_mem_addr,
        input  mem_grant,
        input  mem_byte
    );

    modport slave (
        input  if_mem_req,
        input  if_mem_addr,
        output mem_grant,
        output mem_byte
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: assembles a 32-bit little-endian word from four byte reads.
// Define IF_ICACHE_EN to add a 16-entry direct-mapped instruction cache.
module if_fetch (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [5:0]   stall_i,
    input  logic         branch_flag_i,
    input  logic [31:0]  branch_target_i,
    if_fetch_if.master   mem,
    output logic [31:0]  if_pc_o,
    output logic [31:0]  if_inst_o,
    output logic         stallreq_if_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  issue_q, issue_d;
    logic [1:0]  rcv_q, rcv_d;
    logic        inflight_q, inflight_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic        req_s;
    logic        capture_s;
    logic        last_s;
    logic [31:0] word_s;
    logic        hit_s;
    logic [31:0] hit_word_s;
    logic        unused_stall_s;

    // Only bit 0 of the stall vector concerns this stage.
    assign unused_stall_s = ^stall_i[5:1];

`ifdef IF_ICACHE_EN
    logic [15:0] valid_q;
    logic [11:0] tag_q  [16];
    logic [31:0] data_q [16];
    logic [3:0]  idx_s;
    logic        fill_s;

    assign idx_s      = pc_q[5:2];
    assign hit_s      = (state_q == FETCH) && valid_q[idx_s] && (tag_q[idx_s] == pc_q[17:6]);
    assign hit_word_s = data_q[idx_s];
    // A fetch cancelled by a redirect must not leave its word behind.
    assign fill_s     = last_s && !branch_flag_i;

    // Valid bits, cleared by reset and set on each completed memory fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 16'd0;
        end else if (fill_s) begin
            valid_q[idx_s] <= 1'b1;
        end
    end

    // Tag and data storage, written alongside the valid bit.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_q[idx_s]  <= pc_q[17:6];
            data_q[idx_s] <= word_s;
        end
    end
`else
    assign hit_s      = 1'b0;
    assign hit_word_s = 32'd0;
`endif

    assign req_s     = (state_q == FETCH) && (issue_q < 3'd4) && !hit_s;
    assign capture_s = (state_q == FETCH) && inflight_q;
    assign last_s    = capture_s && (rcv_q == 2'd3);
    assign word_s    = {mem.mem_byte, buf_q[23:0]};

    assign mem.if_mem_req  = req_s;
    assign mem.if_mem_addr = pc_q + {29'd0, issue_q};
    assign if_pc_o         = if_pc_q;
    assign if_inst_o       = if_inst_q;
    assign stallreq_if_o   = (state_q != DONE);

    // Next-state logic; a redirect overrides every other event.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        issue_d    = issue_q;
        rcv_d      = rcv_q;
        inflight_d = req_s && mem.mem_grant;
        buf_d      = buf_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if (branch_flag_i) begin
            state_d    = FETCH;
            pc_d       = branch_target_i;
            issue_d    = 3'd0;
            rcv_d      = 2'd0;
            inflight_d = 1'b0;
            if_pc_d    = 32'd0;
            if_inst_d  = 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = FETCH;
                    issue_d    = 3'd0;
                    rcv_d      = 2'd0;
                    inflight_d = 1'b0;
                end
                FETCH: begin
                    if (hit_s) begin
                        state_d   = DONE;
                        if_pc_d   = pc_q;
                        if_inst_d = hit_word_s;
                    end else begin
                        if (req_s && mem.mem_grant) begin
                            issue_d = issue_q + 3'd1;
                        end else begin
                            issue_d = issue_q;
                        end
                        if (capture_s) begin
                            buf_d[{rcv_q, 3'b000} +: 8] = mem.mem_byte;
                            rcv_d = rcv_q + 2'd1;
                        end else begin
                            rcv_d = rcv_q;
                        end
                        if (last_s) begin
                            state_d   = DONE;
                            if_pc_d   = pc_q;
                            if_inst_d = word_s;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                DONE: begin
                    if (!stall_i[0]) begin
                        state_d = FETCH;
                        pc_d    = pc_q + 32'd4;
                        issue_d = 3'd0;
                        rcv_d   = 2'd0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, PC, byte assembly and presented-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= 32'd0;
            issue_q    <= 3'd0;
            rcv_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf_q      <= 32'd0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            issue_q    <= issue_d;
            rcv_q      <= rcv_d;
            inflight_q <= inflight_d;
            buf_q      <= buf_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random grant,
// stall and redirect traffic checked against a word-level fetch model.
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    if_fetch_if bus ();

    if_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .mem             (bus),
        .if_pc_o         (if_pc),
        .if_inst_o       (if_inst),
        .stallreq_if_o   (stallreq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    logic [7:0]  mem_a [256];
    logic [31:0] exp_pc;
    int          nacc;
    logic        pend_v;
    logic [31:0] pend_a;
    logic        zchk;

    function automatic logic [7:0] mem_at(input logic [31:0] a);
        return mem_a[a[7:0]];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_at(a + 32'd3), mem_at(a + 32'd2), mem_at(a + 32'd1), mem_at(a)};
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One cycle at the current negedge: drive inputs, check against the model, advance it.
    task automatic run_cycle(input logic g, input logic st, input logic br, input logic [31:0] tgt);
        bus.mem_byte   = pend_v ? mem_at(pend_a) : 8'($urandom);
        bus.mem_grant  = g;
        stall          = {5'($urandom), st};
        branch_flag    = br;
        branch_target  = tgt;
        if (zchk) begin
            chk_eq("br_pc", if_pc, 32'd0);
            chk_eq("br_inst", if_inst, 32'd0);
            chk_eq("br_stallreq", 32'(stallreq_if), 32'd1);
            zchk = 1'b0;
        end
        if (!stallreq_if) begin
            chk_eq("done_pc", if_pc, exp_pc);
            chk_eq("done_inst", if_inst, word_at(exp_pc));
            chk_eq("done_req", 32'(bus.if_mem_req), 32'd0);
        end
        pend_v = 1'b0;
        if (bus.if_mem_req && g) begin
            chk_eq("addr", bus.if_mem_addr, exp_pc + 32'(nacc));
            pend_a = bus.if_mem_addr;
            pend_v = 1'b1;
            nacc++;
        end
        if (br) begin
            exp_pc = tgt;
            nacc   = 0;
            zchk   = 1'b1;
        end else if (!stallreq_if && !st) begin
            exp_pc = exp_pc + 32'd4;
            nacc   = 0;
        end
    endtask

    // Runs until a DONE sample (counting the fetch samples before it), then applies st/br there.
    task automatic run_until_done(input logic [31:0] gmask, input logic st, input logic br,
                                  input logic [31:0] tgt, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (stallreq_if === 1'b0) begin
                run_cycle(1'b1, st, br, tgt);
                found = 1'b1;
            end else begin
                run_cycle((i < 32) ? gmask[i] : 1'b1, 1'b0, 1'b0, 32'd0);
                n++;
            end
        end
        if (!found) begin
            chk_eq("done_wait", 32'(stallreq_if), 32'd0);
        end
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_req", 32'(bus.if_mem_req), 32'd0);
        chk_eq("rst_addr", bus.if_mem_addr, 32'd0);
        chk_eq("rst_pc", if_pc, 32'd0);
        chk_eq("rst_inst", if_inst, 32'd0);
        chk_eq("rst_stallreq", 32'(stallreq_if), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_eq("rel_stallreq", 32'(stallreq_if), 32'd1);
        exp_pc = 32'd0;
        nacc   = 0;
        pend_v = 1'b0;
        zchk   = 1'b0;
    endtask

    initial begin
        int n;
        int rq;
        int dn;
        logic [31:0] tgt;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        stall = 6'd0;
        branch_flag   = 1'b0;
        branch_target = 32'd0;
        bus.mem_grant = 1'b0;
        bus.mem_byte  = 8'd0;
        for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom);
        mem_a[0] = 8'h13;
        mem_a[1] = 8'h00;
        mem_a[2] = 8'h00;
        mem_a[3] = 8'h00;
        @(negedge clk);
        apply_reset();

        // First instruction with an always-granting arbiter.
        run_until_done(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n);
        chk_eq("lat_best", 32'(n), 32'd5);
        chk_eq("first_inst", if_inst, 32'h0000_0013);
        chk_eq("first_pc", if_pc, 32'd0);
        chk_eq("first_stallreq", 32'(stallreq_if), 32'd0);

        // Grant withheld for three cycles after the second issue.
        run_until_done(32'hFFFF_FFE3, 1'b1, 1'b0, 32'd0, n);
        chk_eq("lat_gap", 32'(n), 32'd8);

        // Hold in DONE, then release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_eq("hold_stallreq", 32'(stallreq_if), 32'd0);
            run_cycle(1'b1, 1'b1, 1'b0, 32'd0);
        end
        run_until_done(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n);
        chk_eq("hold_release", 32'(n), 32'd0);
        run_until_done(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n);
        chk_eq("lat_after_hold", 32'(n), 32'd5);

        // Redirect on the same edge as the fourth byte capture.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        end
        @(negedge clk);
        run_cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100);
        run_until_done(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n);
        chk_eq("lat_branch", 32'(n), 32'd5);

`ifndef IF_ICACHE_EN
        // Address wrap across 2^32.
        @(negedge clk);
        run_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        run_until_done(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n);
        chk_eq("lat_wrap", 32'(n), 32'd5);
`endif

        // Reset with two bytes already received.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        end
        apply_reset();
        run_until_done(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n);
        chk_eq("lat_after_rst", 32'(n), 32'd5);
        chk_eq("inst_after_rst", if_inst, 32'h0000_0013);

`ifdef IF_ICACHE_EN
        // Two passes over 0x0..0x8; the second must hit every time.
        @(negedge clk);
        apply_reset();
        run_until_done(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n);
        chk_eq("c_miss0", 32'(n), 32'd5);
        run_until_done(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, n);
        run_until_done(32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, n);
        rq = 0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.if_mem_req) rq++;
            if (!stallreq_if) dn++;
            run_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        end
        chk_eq("c_hit_reqs", 32'(rq), 32'd0);
        chk_eq("c_hit_dones", 32'(dn), 32'd3);
`endif

        // Random grant, stall and redirect traffic.
        for (int i = 0; i < 1500; i++) begin
            tgt = $urandom;
`ifdef IF_ICACHE_EN
            tgt = tgt & 32'h0003_FFFC;
`endif
            @(negedge clk);
            run_cycle($urandom_range(0, 9) < 7, ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 24) == 0), tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
